audio_mix_accumulator: RTL

//   Mixing stage between the oscillator/oneshot sources and the I2S output driver.

---
 rtl/audio_mix_accumulator_if.sv | 41 ++++
 rtl/audio_mix_accumulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_accumulator_if.sv
// Bundle between the mixing stage and its neighbours: source samples and
// gains in, the I2S driver's read port, and status/debug out. The mixer
// takes the slave modport. The driver or bench takes the master modport.
interface audio_mix_accumulator_if #(
  parameter int NUM_SRC     = 6,
  parameter int SAMPLE_BITS = 16,
  parameter int GAIN_BITS   = 8,
  parameter int BUF_LEN     = 32
);
  localparam int IDX_W = $clog2(BUF_LEN);

  // Frame clock from the I2S domain. It is asynchronous to mclk.
  logic                           pblrc;
  // Packed sources. Source 0 sits in the LSBs.
  logic [NUM_SRC*SAMPLE_BITS-1:0] src_samples;
  logic [NUM_SRC*GAIN_BITS-1:0]   src_gain;
  // Ring buffer read port used by the I2S driver.
  logic [IDX_W-1:0]               rd_index;
  logic [SAMPLE_BITS-1:0]         rd_sample;
  // Status outputs.
  logic [IDX_W-1:0]               wr_index;
  logic                           mix_valid;
  logic                           busy;
  logic                           clip;
  logic [15:0]                    clip_count;
  logic                           overrun;
  // Current mixer FSM state, exposed for checkers.
  logic [1:0]                     dbg_state;

  modport master (
    output pblrc, src_samples, src_gain, rd_index,
    input  rd_sample, wr_index, mix_valid, busy, clip, clip_count, overrun,
    input  dbg_state
  );

  modport slave (
    input  pblrc, src_samples, src_gain, rd_index,
    output rd_sample, wr_index, mix_valid, busy, clip, clip_count, overrun,
    output dbg_state
  );
endinterface

// File: rtl/audio_mix_accumulator.sv
// Audio mixing stage. Once per audio frame (a falling pblrc edge), the block
// multiplies NUM_SRC signed samples by unsigned gains, where 128 means unity.
// It accumulates the products one source per cycle, saturates the sum to 16
// bits, and writes the result into a ring buffer LAG slots behind the I2S
// driver's read index. The driver reads the ring buffer through a registered
// read port.
//
// Handshake: mix_valid is a one-cycle strobe with no ready. It is high
// exactly in the cycle the ring entry is written. wr_index, clip and
// clip_count take their new values on that same clock edge, so they are
// stable from the cycle after the strobe. There is no back-pressure. A
// frame edge that arrives while busy is dropped and flagged in the sticky
// overrun bit.
module audio_mix_accumulator #(
  parameter int NUM_SRC     = 6,
  parameter int SAMPLE_BITS = 16,
  parameter int GAIN_BITS   = 8,
  parameter int BUF_LEN     = 32,
  parameter int LAG         = 1
) (
  input  logic                  mclk,
  input  logic                  rstn,
  audio_mix_accumulator_if.slave bus
);

  localparam int IDX_W = $clog2(BUF_LEN);
  localparam int CNT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  // The width is sized so that NUM_SRC full-scale products cannot overflow.
  localparam int ACC_W = SAMPLE_BITS + GAIN_BITS + $clog2(NUM_SRC) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_SAT   = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam logic [IDX_W-1:0] LAG_SLOTS = IDX_W'(LAG);
  localparam logic [CNT_W-1:0] LAST_SRC  = CNT_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] SRC_ONE   = CNT_W'(1);

  // These are the saturation bounds, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};
  localparam logic [SAMPLE_BITS-1:0] RES_MAX = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic [SAMPLE_BITS-1:0] RES_MIN = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

  // pblrc synchroniser chain. sync3 is used only for edge detection.
  logic sync1, sync2, sync3;
  logic frame_edge;

  logic [1:0]             state;
  logic [CNT_W-1:0]       src_idx;
  logic signed [ACC_W-1:0] acc;
  logic [SAMPLE_BITS-1:0] snap_samples [NUM_SRC];
  logic [GAIN_BITS-1:0]   snap_gain    [NUM_SRC];
  logic [IDX_W-1:0]       wr_slot;
  logic [SAMPLE_BITS-1:0] res_q;
  logic                   clip_n_q;

  logic [SAMPLE_BITS-1:0] ring [BUF_LEN];
  logic [SAMPLE_BITS-1:0] rd_sample_q;
  logic [IDX_W-1:0]       wr_index_q;
  logic                   clip_q;
  logic [15:0]            clip_count_q;
  logic                   overrun_q;

  // Combinational datapath signals.
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] gain_ext;
  logic signed [ACC_W-1:0] product;
  logic signed [ACC_W-1:0] shifted;
  logic [SAMPLE_BITS-1:0]  res_n;
  logic                    clip_n;

  // Register pblrc through two synchroniser FFs, then one more FF for edge detection.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.pblrc;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign frame_edge = ~sync2 & sync3;

  // Select the current source and form its signed product with the zero-extended gain.
  always_comb begin
    sample_ext = '0;
    gain_ext   = '0;
    sample_ext = {{(ACC_W-SAMPLE_BITS){snap_samples[src_idx][SAMPLE_BITS-1]}},
                  snap_samples[src_idx]};
    gain_ext   = {{(ACC_W-GAIN_BITS){1'b0}}, snap_gain[src_idx]};
    product    = sample_ext * gain_ext;
  end

  // Remove the unity-gain scale with a flooring shift, then clamp to the sample range.
  always_comb begin
    shifted = acc >>> (GAIN_BITS - 1);
    res_n   = shifted[SAMPLE_BITS-1:0];
    clip_n  = 1'b0;
    if (shifted > SAT_MAX) begin
      res_n  = RES_MAX;
      clip_n = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res_n  = RES_MIN;
      clip_n = 1'b1;
    end
  end

  // Run the mixing sequence: IDLE -> ACCUM (one source per cycle) -> SAT -> WRITE.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      src_idx  <= '0;
      acc      <= '0;
      wr_slot  <= '0;
      res_q    <= '0;
      clip_n_q <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        snap_samples[i] <= '0;
        snap_gain[i]    <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_edge) begin
            for (int i = 0; i < NUM_SRC; i++) begin
              snap_samples[i] <= bus.src_samples[i*SAMPLE_BITS +: SAMPLE_BITS];
              snap_gain[i]    <= bus.src_gain[i*GAIN_BITS +: GAIN_BITS];
            end
            wr_slot <= bus.rd_index - LAG_SLOTS;
            acc     <= '0;
            src_idx <= '0;
            state   <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc <= acc + product;
          if (src_idx == LAST_SRC) begin
            state <= ST_SAT;
          end else begin
            src_idx <= src_idx + SRC_ONE;
          end
        end
        ST_SAT: begin
          res_q    <= res_n;
          clip_n_q <= clip_n;
          state    <= ST_WRITE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write the ring buffer. Reset clears every slot so the driver never plays stale data.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BUF_LEN; i++) begin
        ring[i] <= '0;
      end
    end else if (state == ST_WRITE) begin
      ring[wr_slot] <= res_q;
    end
  end

  // Registered read port. A same-cycle write to the read slot returns the old entry.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      rd_sample_q <= '0;
    end else begin
      rd_sample_q <= ring[bus.rd_index];
    end
  end

  // Update the per-frame status (last slot, clip flag and clip counter) on the write cycle.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      wr_index_q   <= '0;
      clip_q       <= 1'b0;
      clip_count_q <= '0;
    end else if (state == ST_WRITE) begin
      wr_index_q <= wr_slot;
      clip_q     <= clip_n_q;
      if (clip_n_q && (clip_count_q != 16'hFFFF)) begin
        clip_count_q <= clip_count_q + 16'd1;
      end
    end
  end

  // Set the sticky overrun flag when a frame edge arrives while a mix is in flight.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      overrun_q <= 1'b0;
    end else if (frame_edge && (state != ST_IDLE)) begin
      overrun_q <= 1'b1;
    end
  end

  // busy covers the edge cycle itself as well as the ACCUM/SAT/WRITE states.
  assign bus.busy       = (state != ST_IDLE) | frame_edge;
  assign bus.mix_valid  = (state == ST_WRITE);
  assign bus.rd_sample  = rd_sample_q;
  assign bus.wr_index   = wr_index_q;
  assign bus.clip       = clip_q;
  assign bus.clip_count = clip_count_q;
  assign bus.overrun    = overrun_q;
  assign bus.dbg_state  = state;

endmodule
